// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC + synchronous-ROM fetch with stall, redirect and optional bound check (IFU_BOUND_CHK_EN)
module inst_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              ROM_AW   = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       inst_code,
  output logic [PC_W-1:0]   pc_out,
  output logic              inst_valid,
  output logic              addr_err
);
  logic [PC_W-1:0] pc_q, pc_d, pc_f2_q, pc_f2_d, tgt;
  logic            valid_q, valid_d, hold;
  assign tgt  = br_target & ~PC_W'(3);
  assign hold = stall && !br_taken;
  assign rom_addr = hold ? pc_f2_q[ROM_AW+1:2] : pc_q[ROM_AW+1:2];
  // next state: redirect beats stall, stall beats sequential advance
  always_comb begin
    pc_d    = br_taken ? tgt : stall ? pc_q : pc_q + PC_W'(4);
    pc_f2_d = hold ? pc_f2_q : pc_q;
    valid_d = br_taken ? 1'b0 : stall ? valid_q : 1'b1;
  end
  // F1/F2 state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      pc_f2_q <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc_f2_q <= pc_f2_d;
      valid_q <= valid_d;
    end
  end
  assign pc_out = pc_f2_q;
`ifdef IFU_BOUND_CHK_EN
  logic err_q, err_d;
  // out-of-range flag travels with its slot through F2
  always_comb begin
    err_d = br_taken ? 1'b0 : stall ? err_q : ((pc_q >> (ROM_AW + 2)) != '0);
  end
  // F2 error register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign addr_err   = err_q;
  assign inst_valid = valid_q && !err_q;
`else
  assign addr_err   = 1'b0;
  assign inst_valid = valid_q;
`endif
  assign inst_code = inst_valid ? rom_data : 32'h0;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of inst_fetch_unit with a synchronous ROM model (honours IFU_BOUND_CHK_EN)
module tb_inst_fetch_unit;
  logic        clk = 0, rst = 0, stall = 0, br_taken = 0;
  logic [31:0] br_target = '0, rom_data, inst_code, pc_out;
  logic [5:0]  rom_addr;
  logic        inst_valid, addr_err;
  logic [31:0] mem [64];
  int n_chk = 0, n_fail = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .rom_addr(rom_addr), .rom_data(rom_data), .inst_code(inst_code), .pc_out(pc_out),
    .inst_valid(inst_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  // synchronous ROM, one-cycle read latency
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [31:0] pc, input logic [31:0] code, input logic v, input logic e);
    chk({tag, " pc"}, pc_out, pc);
    chk({tag, " code"}, inst_code, code);
    chk({tag, " valid"}, {31'b0, inst_valid}, {31'b0, v});
    chk({tag, " err"}, {31'b0, addr_err}, {31'b0, e});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    #2;
    slot("reset", 0, 0, 0, 0);
    edge1();
    slot("reset held", 0, 0, 0, 0);
    rst = 1;
    edge1(); slot("seq0", 32'h0, 32'h1000_0000, 1, 0);
    edge1(); slot("seq1", 32'h4, 32'h1000_0001, 1, 0);
    edge1(); slot("seq2", 32'h8, 32'h1000_0002, 1, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      edge1(); slot("stall", 32'h8, 32'h1000_0002, 1, 0);
    end
    stall = 0;
    edge1(); slot("post stall", 32'hC, 32'h1000_0003, 1, 0);
    edge1(); slot("seq4", 32'h10, 32'h1000_0004, 1, 0);
    br_taken = 1; br_target = 32'h43;
    edge1(); slot("br bubble", 32'h14, 0, 0, 0);
    br_taken = 0;
    edge1(); slot("br tgt", 32'h40, 32'h1000_0010, 1, 0);
    edge1(); slot("br next", 32'h44, 32'h1000_0011, 1, 0);
    stall = 1; br_taken = 1; br_target = 32'h20;
    edge1(); slot("br+stall bubble", 32'h48, 0, 0, 0);
    stall = 0; br_taken = 0;
    edge1(); slot("br+stall tgt", 32'h20, 32'h1000_0008, 1, 0);
    br_taken = 1; br_target = 32'h30;
    edge1(); slot("b2b 1", 32'h24, 0, 0, 0);
    br_target = 32'h8;
    edge1(); slot("b2b 2", 32'h30, 0, 0, 0);
    br_taken = 0;
    edge1(); slot("b2b tgt", 32'h8, 32'h1000_0002, 1, 0);
    edge1(); edge1(); edge1();
    slot("pre reset", 32'h14, 32'h1000_0005, 1, 0);
    edge1(); slot("at 18", 32'h18, 32'h1000_0006, 1, 0);
    #2 rst = 0;
    #1 slot("async reset", 0, 0, 0, 0);
    edge1(); slot("reset hold", 0, 0, 0, 0);
    rst = 1;
    edge1(); slot("restart", 0, 32'h1000_0000, 1, 0);
    br_taken = 1; br_target = 32'h100;
    edge1(); slot("oor bubble", 32'h4, 0, 0, 0);
    br_taken = 0;
`ifdef IFU_BOUND_CHK_EN
    edge1(); slot("oor 100", 32'h100, 0, 0, 1);
    edge1(); slot("oor 104", 32'h104, 0, 0, 1);
`else
    edge1(); slot("oor 100", 32'h100, 32'h1000_0000, 1, 0);
    edge1(); slot("oor 104", 32'h104, 32'h1000_0001, 1, 0);
`endif
    br_taken = 1; br_target = 32'hFFFF_FFFE;
    edge1(); slot("wrap bubble", 32'h108, 0, 0, 0);
    br_taken = 0;
`ifdef IFU_BOUND_CHK_EN
    edge1(); slot("wrap top", 32'hFFFF_FFFC, 0, 0, 1);
`else
    edge1(); slot("wrap top", 32'hFFFF_FFFC, 32'h1000_003F, 1, 0);
`endif
    edge1(); slot("wrap zero", 32'h0, 32'h1000_0000, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
